// File: rtl/ram_if.sv
// Shared-address RAM port bundle: write enable, address, write data and read data.
interface ram_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 4
);
  logic              we;
  logic [ADDR_W-1:0] a;
  logic [DATA_W-1:0] di;
  logic [DATA_W-1:0] rd_data;

  modport master (output we, a, di, input  rd_data);
  modport slave  (input  we, a, di, output rd_data);
endinterface

// File: rtl/ram_infr.sv
// Single-port RAM with registered read address; read data is one clock behind the address and write-first.
// rst clears only the read address register, never the array.
module ram_infr #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 4
) (
  input  logic clk,
  input  logic rst,
  ram_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  // Declaration-time initialisation gives all-zero contents at configuration, so no X can ever be read.
  (* ram_style = "distributed" *)
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};
  logic [ADDR_W-1:0] read_a;

  always_ff @(posedge clk) begin
    if (!rst && bus.we) begin
      mem[bus.a] <= bus.di;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_a <= '0;
    end else begin
      read_a <= bus.a;
    end
  end

  assign bus.rd_data = mem[read_a];
endmodule

// File: tb/tb_ram_infr.sv
// Directed bench for ram_infr: a word-array model checked every cycle plus hand-computed literal checks.
module tb_ram_infr;
  localparam int AW = 5;
  localparam int DW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  ram_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ram_infr #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit model_on = 1'b0;

  logic [DW-1:0] exp_mem [2**AW];
  logic [AW-1:0] exp_ra;

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, want, $time);
    end
  endtask

  // Advance one rising edge and apply the RAM rules to the model with the inputs that were presented.
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      if (bus.we) exp_mem[bus.a] = bus.di;
      exp_ra = bus.a;
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (model_on) check("model", bus.rd_data, exp_mem[exp_ra]);
  end

  function automatic logic [DW-1:0] final_word(input int i);
    case (i)
      0:       return 4'b0001;
      3:       return 4'b1001;
      5:       return 4'b1010;
      10:      return 4'b1100;
      31:      return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  initial begin
    foreach (exp_mem[i]) exp_mem[i] = '0;
    exp_ra = '0;
    bus.we = 1'b0;
    bus.a  = '0;
    bus.di = '0;
    #2;
    check("reset_do", bus.rd_data, 4'b0000);
    model_on = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Basic write/read, back-to-back writes to different words
    bus.we = 1'b1; bus.a = 5'd5;  bus.di = 4'b1010; tick();
    bus.a = 5'd10; bus.di = 4'b1100; tick();
    check("wf_second_write", bus.rd_data, 4'b1100);
    bus.we = 1'b0; bus.a = 5'd5; tick();
    check("read_a5", bus.rd_data, 4'b1010);
    bus.a = 5'd10; tick();
    check("read_a10", bus.rd_data, 4'b1100);

    bus.a = 5'd7; tick();
    check("unwritten_a7", bus.rd_data, 4'b0000);

    // Write-first and same-address rewrite
    bus.we = 1'b1; bus.a = 5'd3; bus.di = 4'b0110; tick();
    check("write_first_0110", bus.rd_data, 4'b0110);
    bus.di = 4'b1001; tick();
    check("rewrite_1001", bus.rd_data, 4'b1001);
    bus.we = 1'b0;

    // Async reset mid-cycle, write suppressed while asserted
    bus.a = 5'd10; tick();
    check("pre_reset_a10", bus.rd_data, 4'b1100);
    #2;
    rst = 1'b1;
    exp_ra = '0;
    #1;
    check("async_reset_do", bus.rd_data, 4'b0000);
    bus.we = 1'b1; bus.a = 5'd0; bus.di = 4'b1111; tick();
    check("write_in_reset", bus.rd_data, 4'b0000);
    rst = 1'b0;
    bus.we = 1'b0; tick();
    check("after_reset_a0", bus.rd_data, 4'b0000);

    // Address extremes
    bus.we = 1'b1; bus.a = 5'd31; bus.di = 4'b1111; tick();
    bus.a = 5'd0; bus.di = 4'b0001; tick();
    bus.we = 1'b0; bus.a = 5'd31; tick();
    check("read_a31", bus.rd_data, 4'b1111);
    bus.a = 5'd0; tick();
    check("read_a0", bus.rd_data, 4'b0001);

    // Hold with stable inputs
    bus.a = 5'd10; tick();
    for (int k = 0; k < 5; k++) begin
      #3;
      check("hold_a10", bus.rd_data, 4'b1100);
      tick();
    end

    // Full readback against hand-derived final contents
    for (int i = 0; i < 2**AW; i++) begin
      bus.a = AW'(i);
      tick();
      check($sformatf("readback_%0d", i), bus.rd_data, final_word(i));
    end

    @(negedge clk);
    model_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
